// File: rtl/qmc_fixed_pkg.sv
// Shared Q-format defaults, saturation helper and batch FSM encoding
// for the regression normal-equation datapath.
package qmc_fixed_pkg;

    localparam int QMC_WIDTH = 32;
    localparam int QMC_FRAC  = 16;
    localparam int WIDE_W    = 128;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    // Clamp a wide signed value into the range of a w-bit signed word.
    function automatic wide_t saturate(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fx_mul_pipe.sv
// Signed Q-format multiplier: full-width product, floor shift by FRAC,
// saturate to WIDTH, then MUL_LATENCY register stages with valid alongside.
module fx_mul_pipe
    import qmc_fixed_pkg::*;
#(
    parameter int WIDTH       = QMC_WIDTH,
    parameter int FRAC        = QMC_FRAC,
    parameter int MUL_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] p,
    output logic                    ovf,
    output logic                    active
);

    logic signed [2*WIDTH-1:0] prod_p0;
    wide_t                     shifted_p0;
    wide_t                     sat_p0;
    logic                      ovf_p0;

    logic signed [WIDTH-1:0] p_pipe [MUL_LATENCY];
    logic [MUL_LATENCY-1:0]  vld_pipe;
    logic [MUL_LATENCY-1:0]  ovf_pipe;

    always_comb begin
        prod_p0    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        shifted_p0 = wide_t'(prod_p0 >>> FRAC);
        sat_p0     = saturate(shifted_p0, WIDTH);
        ovf_p0     = (sat_p0 != shifted_p0);
    end

    // register stages p1..pN
    always_ff @(posedge clk) begin
        p_pipe[0]   <= sat_p0[WIDTH-1:0];
        ovf_pipe[0] <= ovf_p0;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            p_pipe[i]   <= p_pipe[i-1];
            ovf_pipe[i] <= ovf_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[MUL_LATENCY-1];
    assign p         = p_pipe[MUL_LATENCY-1];
    assign ovf       = ovf_pipe[MUL_LATENCY-1] & out_valid;
    assign active    = |vld_pipe;

endmodule

// File: rtl/normal_eq_accum.sv
// Streams (x, y) samples into the power sums of the quadratic basis [1, x, x^2]
// and presents the 3x3 normal-equation matrix and right-hand side.
module normal_eq_accum
    import qmc_fixed_pkg::*;
#(
    parameter int WIDTH       = QMC_WIDTH,
    parameter int FRAC        = QMC_FRAC,
    parameter int MUL_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_x,
    input  logic signed [WIDTH-1:0] s_y,
    input  logic                    s_last,
    output logic [9*WIDTH-1:0]      A_flat,
    output logic [3*WIDTH-1:0]      B_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    overflow
);

    localparam int ACC_W = WIDTH + 8;

    state_t state, state_nxt;
    logic   accept_p0, empty, load_out, clip;

    logic signed [WIDTH-1:0] x_dly  [2*MUL_LATENCY];
    logic signed [WIDTH-1:0] y_dly  [2*MUL_LATENCY];
    logic signed [WIDTH-1:0] x2_dly [MUL_LATENCY];
    logic signed [WIDTH-1:0] xy_dly [MUL_LATENCY];

    logic signed [WIDTH-1:0] x2_p1, xy_p1, x_p1, y_p1;
    logic signed [WIDTH-1:0] x3_p2, x4_p2, x2y_p2, x_p2, y_p2, x2_p2, xy_p2;
    logic vld_x2_p1, vld_xy_p1, ovf_x2_p1, ovf_xy_p1, act_x2, act_xy, vld_p1;
    logic vld_x3_p2, vld_x4_p2, vld_x2y_p2, ovf_x3_p2, ovf_x4_p2, ovf_x2y_p2;
    logic act_x3, act_x4, act_x2y, vld_p2, vld_p3;

    logic signed [ACC_W-1:0] acc_sx, acc_sx2, acc_sx3, acc_sx4, acc_sy, acc_sxy, acc_sx2y;

    wide_t                   a_src [9];
    wide_t                   b_src [3];
    wide_t                   tmp;
    logic [8:0][WIDTH-1:0]   a_sat;
    logic [2:0][WIDTH-1:0]   b_sat;

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (empty) begin
                    load_out  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    assign accept_p0 = s_valid && s_ready;

    // stage 1: x^2 and x*y
    fx_mul_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .MUL_LATENCY(MUL_LATENCY)) u_x2 (
        .clk(clk), .rst(rst), .in_valid(accept_p0), .a(s_x), .b(s_x),
        .out_valid(vld_x2_p1), .p(x2_p1), .ovf(ovf_x2_p1), .active(act_x2));
    fx_mul_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .MUL_LATENCY(MUL_LATENCY)) u_xy (
        .clk(clk), .rst(rst), .in_valid(accept_p0), .a(s_x), .b(s_y),
        .out_valid(vld_xy_p1), .p(xy_p1), .ovf(ovf_xy_p1), .active(act_xy));

    always_ff @(posedge clk) begin
        x_dly[0]  <= s_x;
        y_dly[0]  <= s_y;
        x2_dly[0] <= x2_p1;
        xy_dly[0] <= xy_p1;
        for (int i = 1; i < 2*MUL_LATENCY; i++) begin
            x_dly[i] <= x_dly[i-1];
            y_dly[i] <= y_dly[i-1];
        end
        for (int i = 1; i < MUL_LATENCY; i++) begin
            x2_dly[i] <= x2_dly[i-1];
            xy_dly[i] <= xy_dly[i-1];
        end
    end

    assign vld_p1 = vld_x2_p1 & vld_xy_p1;
    assign x_p1   = x_dly[MUL_LATENCY-1];
    assign y_p1   = y_dly[MUL_LATENCY-1];

    // stage 2: x^3, x^4 and x^2*y from the saturated x^2
    fx_mul_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .MUL_LATENCY(MUL_LATENCY)) u_x3 (
        .clk(clk), .rst(rst), .in_valid(vld_p1), .a(x2_p1), .b(x_p1),
        .out_valid(vld_x3_p2), .p(x3_p2), .ovf(ovf_x3_p2), .active(act_x3));
    fx_mul_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .MUL_LATENCY(MUL_LATENCY)) u_x4 (
        .clk(clk), .rst(rst), .in_valid(vld_p1), .a(x2_p1), .b(x2_p1),
        .out_valid(vld_x4_p2), .p(x4_p2), .ovf(ovf_x4_p2), .active(act_x4));
    fx_mul_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .MUL_LATENCY(MUL_LATENCY)) u_x2y (
        .clk(clk), .rst(rst), .in_valid(vld_p1), .a(x2_p1), .b(y_p1),
        .out_valid(vld_x2y_p2), .p(x2y_p2), .ovf(ovf_x2y_p2), .active(act_x2y));

    assign vld_p2 = vld_x3_p2 & vld_x4_p2 & vld_x2y_p2;
    assign x_p2   = x_dly[2*MUL_LATENCY-1];
    assign y_p2   = y_dly[2*MUL_LATENCY-1];
    assign x2_p2  = x2_dly[MUL_LATENCY-1];
    assign xy_p2  = xy_dly[MUL_LATENCY-1];
    assign empty  = !(act_x2 | act_xy | act_x3 | act_x4 | act_x2y | vld_p3);

    // stage 3: accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p3   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            {acc_sx, acc_sx2, acc_sx3, acc_sx4} <= '0;
            {acc_sy, acc_sxy, acc_sx2y}         <= '0;
        end else if (state == ST_IDLE && start) begin
            vld_p3   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            {acc_sx, acc_sx2, acc_sx3, acc_sx4} <= '0;
            {acc_sy, acc_sxy, acc_sx2y}         <= '0;
        end else begin
            vld_p3 <= vld_p2;
            if (accept_p0) begin
                if (count == '1) overflow <= 1'b1;
                else             count    <= count + 1'b1;
            end
            if (vld_p2) begin
                acc_sx   <= acc_sx   + ACC_W'(x_p2);
                acc_sy   <= acc_sy   + ACC_W'(y_p2);
                acc_sx2  <= acc_sx2  + ACC_W'(x2_p2);
                acc_sxy  <= acc_sxy  + ACC_W'(xy_p2);
                acc_sx3  <= acc_sx3  + ACC_W'(x3_p2);
                acc_sx4  <= acc_sx4  + ACC_W'(x4_p2);
                acc_sx2y <= acc_sx2y + ACC_W'(x2y_p2);
            end
            if (ovf_x2_p1 || ovf_xy_p1 || ovf_x3_p2 || ovf_x4_p2 || ovf_x2y_p2 ||
                (load_out && clip))
                overflow <= 1'b1;
        end
    end

    always_comb begin
        a_src[0] = wide_t'(count) <<< FRAC;
        a_src[1] = wide_t'(acc_sx);
        a_src[2] = wide_t'(acc_sx2);
        a_src[3] = wide_t'(acc_sx);
        a_src[4] = wide_t'(acc_sx2);
        a_src[5] = wide_t'(acc_sx3);
        a_src[6] = wide_t'(acc_sx2);
        a_src[7] = wide_t'(acc_sx3);
        a_src[8] = wide_t'(acc_sx4);
        b_src[0] = wide_t'(acc_sy);
        b_src[1] = wide_t'(acc_sxy);
        b_src[2] = wide_t'(acc_sx2y);
        clip     = 1'b0;
        tmp      = '0;
        a_sat    = '0;
        b_sat    = '0;
        for (int i = 0; i < 9; i++) begin
            tmp      = saturate(a_src[i], WIDTH);
            a_sat[i] = tmp[WIDTH-1:0];
            if (tmp != a_src[i]) clip = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            tmp      = saturate(b_src[i], WIDTH);
            b_sat[i] = tmp[WIDTH-1:0];
            if (tmp != b_src[i]) clip = 1'b1;
        end
    end

    // presentation registers, frozen through HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            A_flat <= '0;
            B_flat <= '0;
        end else if (load_out) begin
            A_flat <= a_sat;
            B_flat <= b_sat;
        end
    end

endmodule

// File: tb/tb_normal_eq_accum.sv
// Randomised and directed bench for normal_eq_accum against a plain-arithmetic
// model of the power sums.
module tb_normal_eq_accum;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int ML = 2;
    localparam int CW = 16;
    localparam longint ONE  = 64'sd65536;
    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, s_valid, s_ready, s_last;
    logic signed [W-1:0] s_x, s_y;
    logic [9*W-1:0]     A_flat;
    logic [3*W-1:0]     B_flat;
    logic               out_valid, out_ready, busy, overflow;
    logic [CW-1:0]      count;

    normal_eq_accum #(.WIDTH(W), .FRAC(F), .MUL_LATENCY(ML), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .s_last(s_last), .A_flat(A_flat), .B_flat(B_flat),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .count(count),
        .overflow(overflow));

    int n_cmp  = 0;
    int n_fail = 0;

    longint     qx[$];
    longint     qy[$];
    logic [31:0] exp_a[9];
    logic [31:0] exp_b[3];
    logic        exp_ovf;

    function automatic longint clamp(input longint v, inout bit ov);
        if (v > QMAX) begin ov = 1; return QMAX; end
        if (v < QMIN) begin ov = 1; return QMIN; end
        return v;
    endfunction

    // Q16.16 product, floor-rounded and clamped to the 32-bit word
    function automatic longint fix_mul(input longint a, input longint b, inout bit ov);
        return clamp((a * b) >>> F, ov);
    endfunction

    task automatic model_batch();
        longint sx = 0, sx2 = 0, sx3 = 0, sx4 = 0, sy = 0, sxy = 0, sx2y = 0;
        longint x2, t;
        longint av[9];
        longint bv[3];
        bit ov = 0;
        foreach (qx[i]) begin
            x2    = fix_mul(qx[i], qx[i], ov);
            sx   += qx[i];
            sy   += qy[i];
            sx2  += x2;
            sxy  += fix_mul(qx[i], qy[i], ov);
            sx3  += fix_mul(x2, qx[i], ov);
            sx4  += fix_mul(x2, x2, ov);
            sx2y += fix_mul(x2, qy[i], ov);
        end
        av = '{longint'(qx.size()) * ONE, sx, sx2, sx, sx2, sx3, sx2, sx3, sx4};
        bv = '{sy, sxy, sx2y};
        for (int i = 0; i < 9; i++) begin t = clamp(av[i], ov); exp_a[i] = t[31:0]; end
        for (int i = 0; i < 3; i++) begin t = clamp(bv[i], ov); exp_b[i] = t[31:0]; end
        exp_ovf = ov;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_batch(input int gap_pct, input bit poke_start);
        for (int i = 0; i < qx.size(); i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                start   = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
            end
            start   = 1'b0;
            s_valid = 1'b1;
            s_x     = 32'(qx[i]);
            s_y     = 32'(qy[i]);
            s_last  = (i == qx.size() - 1);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; out_ready = 1'b0;
        s_x = '0; s_y = '0;
        repeat (3) step();
        rst = 1'b0;
        n_cmp += 7;
        if (s_ready !== 1'b0)   begin n_fail++; $display("FAIL reset s_ready got %b want 0", s_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset overflow got %b want 0", overflow); end
        if (count !== '0)       begin n_fail++; $display("FAIL reset count got %0d want 0", count); end
        if (A_flat !== '0)      begin n_fail++; $display("FAIL reset A_flat got %h want 0", A_flat); end
        if (B_flat !== '0)      begin n_fail++; $display("FAIL reset B_flat got %h want 0", B_flat); end
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] got;
        qx = '{1 * ONE, 2 * ONE, 3 * ONE};
        qy = '{2 * ONE, 4 * ONE, 6 * ONE};
        model_batch();
        do_start();
        send_batch(0, 0);
        wait_out(lat);
        n_cmp++;
        if (lat != 2 * ML + 2) begin n_fail++; $display("FAIL basic latency got %0d want %0d", lat, 2 * ML + 2); end
        for (int i = 0; i < 9; i++) begin
            got = A_flat[i*W +: W];
            n_cmp++;
            if (got !== exp_a[i]) begin n_fail++; $display("FAIL basic A[%0d] got %h want %h", i, got, exp_a[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            got = B_flat[i*W +: W];
            n_cmp++;
            if (got !== exp_b[i]) begin n_fail++; $display("FAIL basic B[%0d] got %h want %h", i, got, exp_b[i]); end
        end
        n_cmp += 3;
        if (A_flat[8*W +: W] !== 32'h0062_0000) begin n_fail++; $display("FAIL basic Sx4 got %h want 00620000", A_flat[8*W +: W]); end
        if (count !== 16'd3)    begin n_fail++; $display("FAIL basic count got %0d want 3", count); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL basic overflow got %b want 0", overflow); end
        accept_out();
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic out_valid after accept got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic busy after accept got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [9*W-1:0] cap_a;
        logic [3*W-1:0] cap_b;
        qx = '{ONE / 2, 3 * ONE / 2, -ONE, 5 * ONE / 4};
        qy = '{ONE, -2 * ONE, ONE / 4, 3 * ONE};
        model_batch();
        do_start();
        send_batch(0, 0);
        wait_out(lat);
        cap_a = A_flat;
        cap_b = B_flat;
        n_cmp += 2;
        if (cap_a !== {exp_a[8], exp_a[7], exp_a[6], exp_a[5], exp_a[4], exp_a[3], exp_a[2], exp_a[1], exp_a[0]})
            begin n_fail++; $display("FAIL bp A_flat got %h", cap_a); end
        if (cap_b !== {exp_b[2], exp_b[1], exp_b[0]})
            begin n_fail++; $display("FAIL bp B_flat got %h", cap_b); end
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_x = 32'(ONE); s_y = 32'(ONE); start = 1'b1;
            step();
            n_cmp += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp out_valid cyc %0d got %b want 1", k, out_valid); end
            if (s_ready !== 1'b0)   begin n_fail++; $display("FAIL bp s_ready cyc %0d got %b want 0", k, s_ready); end
            if (A_flat !== cap_a || B_flat !== cap_b)
                begin n_fail++; $display("FAIL bp stable cyc %0d got %h want %h", k, A_flat, cap_a); end
            if (count !== 16'd4)    begin n_fail++; $display("FAIL bp count cyc %0d got %0d want 4", k, count); end
        end
        s_valid = 1'b0; start = 1'b0;
        accept_out();
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp accept out_valid got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL bp accept busy got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        int lat;
        qx = '{100 * ONE};
        qy = '{ONE};
        do_start();
        send_batch(0, 0);
        wait_out(lat);
        n_cmp += 4;
        if (A_flat[8*W +: W] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat A[8] got %h want 7fffffff", A_flat[8*W +: W]); end
        if (A_flat[4*W +: W] !== 32'h2710_0000) begin n_fail++; $display("FAIL sat A[4] got %h want 27100000", A_flat[4*W +: W]); end
        if (A_flat[5*W +: W] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat A[5] got %h want 7fffffff", A_flat[5*W +: W]); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat overflow got %b want 1", overflow); end
        accept_out();
    endtask

    task automatic test_negative();
        int lat;
        qx = '{-2 * ONE};
        qy = '{ONE};
        do_start();
        send_batch(0, 0);
        wait_out(lat);
        n_cmp += 5;
        if (A_flat[1*W +: W] !== 32'hFFFE_0000) begin n_fail++; $display("FAIL neg Sx got %h want fffe0000", A_flat[1*W +: W]); end
        if (A_flat[5*W +: W] !== 32'hFFF8_0000) begin n_fail++; $display("FAIL neg Sx3 got %h want fff80000", A_flat[5*W +: W]); end
        if (B_flat[1*W +: W] !== 32'hFFFE_0000) begin n_fail++; $display("FAIL neg Sxy got %h want fffe0000", B_flat[1*W +: W]); end
        if (A_flat[8*W +: W] !== 32'h0010_0000) begin n_fail++; $display("FAIL neg Sx4 got %h want 00100000", A_flat[8*W +: W]); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL neg overflow got %b want 0", overflow); end
        accept_out();
    endtask

    task automatic test_reset_mid_batch();
        int lat;
        logic [31:0] got;
        do_start();
        s_valid = 1'b1; s_last = 1'b0; s_x = 32'(100 * ONE); s_y = 32'(ONE);
        step();
        s_x = 32'(7 * ONE); s_y = 32'(-3 * ONE);
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp += 2;
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst busy got %b want 0", busy); end
        if (count !== '0)   begin n_fail++; $display("FAIL midrst count got %0d want 0", count); end
        qx = '{ONE};
        qy = '{ONE};
        do_start();
        send_batch(0, 0);
        wait_out(lat);
        for (int i = 0; i < 12; i++) begin
            got = (i < 9) ? A_flat[i*W +: W] : B_flat[(i-9)*W +: W];
            n_cmp++;
            if (got !== 32'h0001_0000) begin n_fail++; $display("FAIL midrst elem %0d got %h want 00010000", i, got); end
        end
        n_cmp += 2;
        if (count !== 16'd1)   begin n_fail++; $display("FAIL midrst count got %0d want 1", count); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst overflow got %b want 0", overflow); end
        accept_out();
    endtask

    task automatic test_random();
        int lat, len;
        logic [31:0] got;
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 12);
            qx.delete();
            qy.delete();
            for (int i = 0; i < len; i++) begin
                qx.push_back(longint'($urandom_range(0, 1 << 20)) - (1 << 19));
                qy.push_back(longint'($urandom_range(0, 1 << 20)) - (1 << 19));
            end
            model_batch();
            do_start();
            send_batch(30, 1);
            wait_out(lat);
            n_cmp++;
            if (lat != 2 * ML + 2) begin n_fail++; $display("FAIL rand%0d latency got %0d want %0d", b, lat, 2 * ML + 2); end
            for (int i = 0; i < 9; i++) begin
                got = A_flat[i*W +: W];
                n_cmp++;
                if (got !== exp_a[i]) begin n_fail++; $display("FAIL rand%0d A[%0d] got %h want %h", b, i, got, exp_a[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                got = B_flat[i*W +: W];
                n_cmp++;
                if (got !== exp_b[i]) begin n_fail++; $display("FAIL rand%0d B[%0d] got %h want %h", b, i, got, exp_b[i]); end
            end
            n_cmp += 2;
            if (count !== CW'(len))    begin n_fail++; $display("FAIL rand%0d count got %0d want %0d", b, count, len); end
            if (overflow !== exp_ovf)  begin n_fail++; $display("FAIL rand%0d overflow got %b want %b", b, overflow, exp_ovf); end
            accept_out();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_negative();
        test_reset_mid_batch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
